ofm_stream_reader: RTL and testbench

OFM_STREAM_READER -- requirements
Module: ofm_stream_reader

---
 rtl/ofm_stream_reader_if.sv | 30 +++
 rtl/ofm_stream_reader.sv | 202 ++++++++++++++++++++
 tb/tb_ofm_stream_reader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ofm_stream_reader_if.sv
// Handshake and bus bundle for the OFM stream reader: control, RAM read port and output beat stream.
interface ofm_stream_reader_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned INOUT_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH  = 17
);
  localparam int unsigned WPB = INOUT_WIDTH / (2 * DATA_WIDTH);

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    ram_rd_en;
  logic [ADDR_WIDTH-1:0]   ram_rd_addr;
  logic [2*DATA_WIDTH-1:0] ram_rd_data;
  logic                    m_valid;
  logic                    m_ready;
  logic [INOUT_WIDTH-1:0]  m_data;
  logic [WPB-1:0]          m_keep;
  logic                    m_last;

  modport master (
    input  start, ram_rd_data, m_ready,
    output busy, done, ram_rd_en, ram_rd_addr, m_valid, m_data, m_keep, m_last
  );

  modport slave (
    output start, ram_rd_data, m_ready,
    input  busy, done, ram_rd_en, ram_rd_addr, m_valid, m_data, m_keep, m_last
  );
endinterface

// File: rtl/ofm_stream_reader.sv
// Drains the OFM RAM in address order and packs WPB words per output beat,
// with a one-beat pack buffer behind a registered output stage.
module ofm_stream_reader #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned INOUT_WIDTH      = 128,
  parameter int unsigned OFM_SIZE_POOLING = 26,
  parameter int unsigned NO_FILTER        = 128,
  parameter int unsigned ADDR_WIDTH       = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  ofm_stream_reader_if.master  bus
);
  localparam int unsigned WW    = 2 * DATA_WIDTH;
  localparam int unsigned WPB   = INOUT_WIDTH / WW;
  localparam int unsigned TOTAL = OFM_SIZE_POOLING * OFM_SIZE_POOLING * NO_FILTER;
  localparam int unsigned CW    = $clog2(WPB + 1);
  localparam int unsigned SW    = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int unsigned OW    = $clog2(2 * WPB + 1);
  localparam int unsigned NW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_e;

  state_e state_q, state_d;

  logic                   armed_q;
  logic                   busy_q, busy_d, done_q, done_d;
  logic                   rd_en_q, rd_en_d, rd_vld_q, rd_vld_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [NW-1:0]          issued_q, issued_d, cap_q, cap_d;
  logic [OW-1:0]          occ_q, occ_d, occ_after;
  logic [INOUT_WIDTH-1:0] pack_q, pack_d, pack_n;
  logic [CW-1:0]          pcnt_q, pcnt_d, cnt_n;
  logic                   pfull_q, pfull_d, plast_q, plast_d;
  logic                   mvalid_q, mvalid_d, mlast_q, mlast_d;
  logic [INOUT_WIDTH-1:0] mdata_q, mdata_d;
  logic [WPB-1:0]         mkeep_q, mkeep_d;
  logic [CW-1:0]          mcnt_q, mcnt_d;
  logic [SW-1:0]          slot;
  logic                   start_ok, acc, out_free, moved, fin, issue, last_issue;

  function automatic logic [WPB-1:0] keep_of(input logic [CW-1:0] n);
    for (int unsigned i = 0; i < WPB; i++) keep_of[i] = (CW'(i) < n);
  endfunction

  // Reads are credited against everything issued but not yet accepted downstream (output + pack).
  always_comb begin
    start_ok   = armed_q && bus.start && (state_q == IDLE);
    acc        = mvalid_q && bus.m_ready;
    occ_after  = occ_q - (acc ? OW'(mcnt_q) : OW'(0));
    issue      = (start_ok || (state_q == READ)) && (occ_after < OW'(2 * WPB));
    last_issue = issue && (issued_q == NW'(TOTAL - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = last_issue ? FLUSH : READ;
      READ:    if (last_issue) state_d = FLUSH;
      FLUSH:   if (acc && mlast_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    rd_en_d  = issue;
    rd_vld_d = rd_en_q;
    addr_d   = addr_q;
    issued_d = issued_q;
    cap_d    = cap_q;
    occ_d    = occ_after + OW'(issue);
    pack_d   = pack_q;
    pcnt_d   = pcnt_q;
    pfull_d  = pfull_q;
    plast_d  = plast_q;
    mvalid_d = mvalid_q;
    mdata_d  = mdata_q;
    mkeep_d  = mkeep_q;
    mlast_d  = mlast_q;
    mcnt_d   = mcnt_q;
    out_free = !mvalid_q || bus.m_ready;
    moved    = 1'b0;
    pack_n   = '0;
    cnt_n    = '0;
    slot     = '0;
    fin      = 1'b0;

    if (issue) begin
      addr_d   = issued_q[ADDR_WIDTH-1:0];
      issued_d = issued_q + NW'(1);
    end

    if (acc) mvalid_d = 1'b0;

    if (pfull_q && out_free) begin
      mvalid_d = 1'b1;
      mdata_d  = pack_q;
      mkeep_d  = keep_of(pcnt_q);
      mlast_d  = plast_q;
      mcnt_d   = pcnt_q;
      pack_d   = '0;
      pcnt_d   = '0;
      pfull_d  = 1'b0;
      plast_d  = 1'b0;
      moved    = 1'b1;
    end

    // A completing word goes straight to the output when it is free, saving a cycle per beat.
    if (rd_vld_q) begin
      slot   = pcnt_d[SW-1:0];
      pack_n = pack_d;
      pack_n[slot*WW +: WW] = bus.ram_rd_data;
      cnt_n  = pcnt_d + CW'(1);
      fin    = (cap_q == NW'(TOTAL - 1));
      cap_d  = cap_q + NW'(1);
      if ((cnt_n == CW'(WPB)) || fin) begin
        if (out_free && !moved) begin
          mvalid_d = 1'b1;
          mdata_d  = pack_n;
          mkeep_d  = keep_of(cnt_n);
          mlast_d  = fin;
          mcnt_d   = cnt_n;
          pack_d   = '0;
          pcnt_d   = '0;
        end else begin
          pack_d  = pack_n;
          pcnt_d  = cnt_n;
          pfull_d = 1'b1;
          plast_d = fin;
        end
      end else begin
        pack_d = pack_n;
        pcnt_d = cnt_n;
      end
    end

    if (state_q == DONE) begin
      issued_d = '0;
      cap_d    = '0;
      occ_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      addr_q   <= '0;
      issued_q <= '0;
      cap_q    <= '0;
      occ_q    <= '0;
      pack_q   <= '0;
      pcnt_q   <= '0;
      pfull_q  <= 1'b0;
      plast_q  <= 1'b0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
      mkeep_q  <= '0;
      mlast_q  <= 1'b0;
      mcnt_q   <= '0;
    end else begin
      armed_q  <= 1'b1;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      rd_vld_q <= rd_vld_d;
      addr_q   <= addr_d;
      issued_q <= issued_d;
      cap_q    <= cap_d;
      occ_q    <= occ_d;
      pack_q   <= pack_d;
      pcnt_q   <= pcnt_d;
      pfull_q  <= pfull_d;
      plast_q  <= plast_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
      mkeep_q  <= mkeep_d;
      mlast_q  <= mlast_d;
      mcnt_q   <= mcnt_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.ram_rd_en   = rd_en_q;
  assign bus.ram_rd_addr = addr_q;
  assign bus.m_valid     = mvalid_q;
  assign bus.m_data      = mdata_q;
  assign bus.m_keep      = mkeep_q;
  assign bus.m_last      = mlast_q;
endmodule

// File: tb/tb_ofm_stream_reader.sv
// Bench for ofm_stream_reader: table of drain scenarios against a word-list reference model,
// plus hand-written reset and restart sequences.
module tb_ofm_stream_reader;
  localparam int unsigned DW    = 8;
  localparam int unsigned IW    = 128;
  localparam int unsigned AW    = 17;
  localparam int unsigned SP    = 2;
  localparam int unsigned NF    = 3;
  localparam int unsigned WPB   = IW / (2 * DW);
  localparam int unsigned TOTAL = SP * SP * NF;
  localparam int unsigned NBEAT = (TOTAL + WPB - 1) / WPB;

  typedef struct {
    logic [IW-1:0]  data;
    logic [WPB-1:0] keep;
    logic           last;
  } beat_t;

  typedef struct {
    int stall;
    int pct;
    bit repulse;
    bit seq_ram;
    int exp_reads;
    int exp_beats;
    int exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ofm_stream_reader_if #(.DATA_WIDTH(DW), .INOUT_WIDTH(IW), .ADDR_WIDTH(AW)) bif ();

  ofm_stream_reader #(
    .DATA_WIDTH(DW), .INOUT_WIDTH(IW), .OFM_SIZE_POOLING(SP), .NO_FILTER(NF), .ADDR_WIDTH(AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2*DW-1:0] mem [TOTAL];
  always @(posedge clk)
    if (bif.ram_rd_en && int'(bif.ram_rd_addr) < int'(TOTAL)) bif.ram_rd_data <= mem[int'(bif.ram_rd_addr)];

  bit drv_en = 0;
  int stall = 0, pct = 100, s_cyc = 0;
  always @(posedge clk) begin
    #1;
    if (!drv_en || (cyc - s_cyc) < stall) bif.m_ready = 1'b0;
    else bif.m_ready = ($urandom_range(0, 99) < pct);
  end

  task automatic chk(input bit ok, input string name, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  bit    mon_en = 0;
  int    reads_q[$];
  beat_t beats_q[$];
  int    done_cnt, done_cyc, last_acc, first_v;
  bit    hold_pend = 0;
  beat_t hold_b;

  always @(negedge clk) if (mon_en) begin
    if (bif.ram_rd_en) reads_q.push_back(int'(bif.ram_rd_addr));
    if (bif.m_valid && first_v < 0) first_v = cyc;
    if (hold_pend)
      chk(bif.m_valid && bif.m_data == hold_b.data && bif.m_keep == hold_b.keep && bif.m_last == hold_b.last,
          "beat_hold", bif.m_data, hold_b.data);
    hold_pend   = bif.m_valid && !bif.m_ready;
    hold_b.data = bif.m_data;
    hold_b.keep = bif.m_keep;
    hold_b.last = bif.m_last;
    if (bif.m_valid && bif.m_ready) begin
      beats_q.push_back(hold_b);
      if (bif.m_last) last_acc = cyc + 1;
    end
    if (bif.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic run_drain(input vec_t v);
    beat_t exp_q[$];
    beat_t b;
    bit    ok;
    int    bad;
    for (int k = 0; k < int'(TOTAL); k++) mem[k] = v.seq_ram ? (2*DW)'(k + 1) : (2*DW)'($urandom);
    // Reference: word k lands in beat k/WPB, slot k%WPB; the partial last beat is zero-padded.
    for (int bi = 0; bi < int'(NBEAT); bi++) begin
      b.data = '0;
      b.keep = '0;
      for (int j = 0; j < int'(WPB); j++) begin
        if (bi * int'(WPB) + j < int'(TOTAL)) begin
          b.data[j*2*DW +: 2*DW] = mem[bi * int'(WPB) + j];
          b.keep[j] = 1'b1;
        end
      end
      b.last = (bi == int'(NBEAT) - 1);
      exp_q.push_back(b);
    end
    reads_q.delete();
    beats_q.delete();
    done_cnt = 0; done_cyc = -1; last_acc = -2; first_v = -1; hold_pend = 0;
    stall = v.stall;
    pct = v.pct;
    mon_en = 1;
    @(posedge clk); #1 bif.start = 1'b1;
    @(posedge clk); #1 bif.start = 1'b0;
    s_cyc = cyc;
    drv_en = 1;
    @(negedge clk);
    chk(bif.busy == 1'b1, "busy_after_start", IW'(bif.busy), IW'(1));
    if (v.repulse) begin
      repeat (4) @(posedge clk);
      #1 bif.start = 1'b1;
      @(posedge clk); #1 bif.start = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      @(negedge clk);
      if (v.stall >= 20 && cyc == s_cyc + 18) begin
        chk(reads_q.size() == int'(TOTAL), "stall_reads_done", IW'(reads_q.size()), IW'(TOTAL));
        chk(beats_q.size() == 0 && bif.m_valid, "stall_beat_waiting", IW'(beats_q.size()), IW'(0));
      end
    end
    chk(done_cnt != 0, "done_timeout", IW'(done_cnt), IW'(1));
    repeat (4) @(negedge clk);
    chk(done_cnt == v.exp_done, "done_count", IW'(done_cnt), IW'(v.exp_done));
    chk(done_cyc == last_acc, "done_timing", IW'(done_cyc), IW'(last_acc));
    chk(bif.busy == 1'b0, "busy_idle_after_done", IW'(bif.busy), IW'(0));
    if (v.stall == 0 && v.pct == 100)
      chk(first_v == s_cyc + int'(WPB) + 1, "first_valid_latency", IW'(first_v - s_cyc), IW'(WPB + 1));
    chk(beats_q.size() == v.exp_beats, "beat_count", IW'(beats_q.size()), IW'(v.exp_beats));
    for (int bi = 0; bi < beats_q.size() && bi < exp_q.size(); bi++) begin
      chk(beats_q[bi].data == exp_q[bi].data, "beat_data", beats_q[bi].data, exp_q[bi].data);
      chk(beats_q[bi].keep == exp_q[bi].keep, "beat_keep", IW'(beats_q[bi].keep), IW'(exp_q[bi].keep));
      chk(beats_q[bi].last == exp_q[bi].last, "beat_last", IW'(beats_q[bi].last), IW'(exp_q[bi].last));
    end
    chk(reads_q.size() == v.exp_reads, "read_count", IW'(reads_q.size()), IW'(v.exp_reads));
    ok = 1; bad = 0;
    for (int i = 0; i < reads_q.size(); i++)
      if (ok && reads_q[i] != i) begin ok = 0; bad = i; end
    chk(ok, "addr_seq", IW'(ok ? 0 : reads_q[bad]), IW'(bad));
    mon_en = 0;
    drv_en = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk(bif.busy == 0 && bif.done == 0 && bif.ram_rd_en == 0 && bif.ram_rd_addr == '0,
        {tag, "_ctrl_zero"}, IW'({bif.busy, bif.done, bif.ram_rd_en, bif.ram_rd_addr}), IW'(0));
    chk(bif.m_valid == 0 && bif.m_data == '0 && bif.m_keep == '0 && bif.m_last == 0,
        {tag, "_stream_zero"}, bif.m_data | IW'({bif.m_valid, bif.m_keep, bif.m_last}), IW'(0));
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{0,    100, 1'b0, 1'b1, int'(TOTAL), int'(NBEAT), 1};
    vecs[1] = '{20,   100, 1'b0, 1'b1, int'(TOTAL), int'(NBEAT), 1};
    vecs[2] = '{0,    50,  1'b0, 1'b1, int'(TOTAL), int'(NBEAT), 1};
    vecs[3] = '{0,    50,  1'b0, 1'b0, int'(TOTAL), int'(NBEAT), 1};
    vecs[4] = '{3,    30,  1'b0, 1'b0, int'(TOTAL), int'(NBEAT), 1};
    vecs[5] = '{0,    100, 1'b1, 1'b1, int'(TOTAL), int'(NBEAT), 1};
    vecs[6] = '{0,    70,  1'b0, 1'b0, int'(TOTAL), int'(NBEAT), 1};

    bif.start = 1'b0;
    bif.m_ready = 1'b0;
    bif.ram_rd_data = '0;
    repeat (3) @(posedge clk);
    #2 check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("post_reset_idle");

    for (int i = 0; i < 7; i++) run_drain(vecs[i]);

    // Asynchronous reset with five words packed and the output stalled.
    for (int k = 0; k < int'(TOTAL); k++) mem[k] = (2*DW)'(k + 1);
    stall = 1000; drv_en = 1;
    @(posedge clk); #1 bif.start = 1'b1;
    @(posedge clk); #1 bif.start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    drv_en = 0;
    @(posedge clk); #1 bif.start = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 bif.start = 1'b0;
    @(negedge clk);
    check_all_zero("start_at_release");
    repeat (3) @(negedge clk);
    check_all_zero("release_quiet");

    run_drain(vecs[0]);
    run_drain(vecs[3]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
